// File: rtl/branch_predict_unit_pkg.sv
// Shared types for the branch predictor.
//   word_t        : 32-bit machine word / PC
//   bpu_resolve_t : bundle describing the instruction resolving in EX
//   pc_plus4      : sequential next-PC, wraps at the top of the address space
package branch_predict_unit_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic  valid;       // real instruction, not a bubble
    logic  is_br;       // beq/bne
    logic  is_jmp;      // j/jal
    word_t pc;
    logic  taken;       // resolved direction
    word_t target;      // resolved target
    logic  pred_taken;  // prediction made in IF for this instruction
    word_t pred_npc;
  } bpu_resolve_t;

  function automatic word_t pc_plus4(input word_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/branch_predict_unit_sat_counter.sv
// Saturating up/down counter holding one BTB entry's direction state.
//   clk, rst_n : clock, async active-low reset (resets to weakly not-taken)
//   inc, dec   : step toward taken / not-taken, clamped at the ends
//   load       : overwrite with load_val (wins over inc/dec)
//   cnt        : current state; MSB=1 means predict taken
module bpu_sat_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_RST = CNT_MAX >> 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= CNT_RST;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc) begin
      if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
    end else if (dec) begin
      if (cnt != '0) cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Dynamic branch/jump predictor: direct-mapped BTB with a saturating
// direction counter per entry.
//   CLK, nRST            : clock, async active-low reset
//   if_pc                : fetch PC; pred_taken / pred_npc are its prediction
//   ex_*                 : branch/jump resolving in EX (ex_en gates all updates)
//   mispredict, redirect_pc : EX redirect request and the correct next PC
//   perf_ctrl, perf_miss : resolved control-transfer and mispredict counts
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int MODE    = 1,
  parameter int PERF_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  word_t             if_pc,
  output logic              pred_taken,
  output word_t             pred_npc,
  input  logic              ex_en,
  input  logic              ex_valid,
  input  logic              ex_is_br,
  input  logic              ex_is_jmp,
  input  word_t             ex_pc,
  input  logic              ex_taken,
  input  word_t             ex_target,
  input  logic              ex_pred_taken,
  input  word_t             ex_pred_npc,
  output logic              mispredict,
  output word_t             redirect_pc,
  output logic [PERF_W-1:0] perf_ctrl,
  output logic [PERF_W-1:0] perf_miss
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam bit DYN   = (MODE != 0);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [29:0]      target;  // word address, low two bits implied zero
    logic [CNT_W-1:0] cnt;
  } bpu_entry_t;

  bpu_entry_t tbl [ENTRIES];

  bpu_resolve_t res;
  assign res = '{valid: ex_valid, is_br: ex_is_br, is_jmp: ex_is_jmp, pc: ex_pc,
                 taken: ex_taken, target: ex_target, pred_taken: ex_pred_taken,
                 pred_npc: ex_pred_npc};

  // ---------------- IF lookup (combinational, sees pre-update table) -------
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  bpu_entry_t       if_ent;
  logic             if_hit;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[31:IDX_W+2];
  assign if_ent = tbl[if_idx];
  assign if_hit = if_ent.valid && (if_ent.tag == if_tag);

  assign pred_taken = DYN && if_hit && if_ent.cnt[CNT_W-1];
  assign pred_npc   = pred_taken ? {if_ent.target, 2'b00} : pc_plus4(if_pc);

  // ---------------- EX check ------------------------------------------------
  // Comparing the full next PC catches wrong direction, wrong target and a
  // non-control instruction that aliased onto a taken entry.
  assign redirect_pc = res.taken ? res.target : pc_plus4(res.pc);
  assign mispredict  = res.valid && (redirect_pc != res.pred_npc);

  // ---------------- EX training ---------------------------------------------
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  bpu_entry_t       ex_ent;
  logic             ex_hit, is_ctrl, upd;
  logic             hit_tk, hit_nt, alloc, alias_clr;
  logic [CNT_W-1:0] alloc_cnt;

  assign ex_idx  = res.pc[IDX_W+1:2];
  assign ex_tag  = res.pc[31:IDX_W+2];
  assign ex_ent  = tbl[ex_idx];
  assign ex_hit  = ex_ent.valid && (ex_ent.tag == ex_tag);
  assign is_ctrl = res.valid && (res.is_br || res.is_jmp);
  assign upd     = ex_en && is_ctrl && DYN;

  assign hit_tk    = upd && ex_hit && res.taken;
  assign hit_nt    = upd && ex_hit && !res.taken;
  assign alloc     = upd && !ex_hit && res.taken;
  // Jumps are always taken, so they start saturated; branches start weakly taken.
  assign alloc_cnt = res.is_jmp ? CNT_MAX : CNT_WT;
  // A non-control instruction that was predicted taken hit a stale alias;
  // drop the entry so the same fetch stops redirecting.
  assign alias_clr = ex_en && DYN && res.valid && !res.is_br && !res.is_jmp && res.pred_taken;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
    logic             sel, valid_q;
    logic [TAG_W-1:0] tag_q;
    logic [29:0]      tgt_q;
    logic [CNT_W-1:0] cnt_q;

    assign sel = (ex_idx == IDX_W'(i));

    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        valid_q <= 1'b0;
        tag_q   <= '0;
        tgt_q   <= '0;
      end else if (sel) begin
        if (alloc) begin
          valid_q <= 1'b1;
          tag_q   <= ex_tag;
          tgt_q   <= res.target[31:2];
        end else if (hit_tk) begin
          tgt_q   <= res.target[31:2];
        end else if (alias_clr) begin
          valid_q <= 1'b0;
        end
      end
    end

    bpu_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (CLK),
      .rst_n    (nRST),
      .inc      (sel && hit_tk),
      .dec      (sel && hit_nt),
      .load     (sel && alloc),
      .load_val (alloc_cnt),
      .cnt      (cnt_q)
    );

    assign tbl[i] = {valid_q, tag_q, tgt_q, cnt_q};
  end

  // ---------------- performance counters -----------------------------------
  // Counted independently of MODE so static and dynamic runs compare directly.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_ctrl <= '0;
      perf_miss <= '0;
    end else if (ex_en) begin
      if (is_ctrl)    perf_ctrl <= perf_ctrl + PERF_W'(1);
      if (mispredict) perf_miss <= perf_miss + PERF_W'(1);
    end
  end

  // Byte-offset bits of word-aligned addresses carry no information.
  logic unused_lsbs;
  assign unused_lsbs = ^{if_pc[1:0], ex_pc[1:0], ex_target[1:0]};

endmodule
